// File: rtl/li_expander_if.sv
// Handshake bus for li_expander: constant/register request in, instruction word out.
interface li_expander_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic [4:0]  in_rt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [1:0]  out_eop;
  logic        out_last;

  modport slave (
    input  in_valid, in_value, in_rt, out_ready,
    output in_ready, out_valid, out_instr, out_eop, out_last
  );

  modport master (
    output in_valid, in_value, in_rt, out_ready,
    input  in_ready, out_valid, out_instr, out_eop, out_last
  );
endinterface

// File: rtl/li_expander.sv
// Expands a 32-bit constant into the shortest MIPS load sequence (ADDIU/ORI/LUI or LUI+ORI),
// tagging each word with the extender op needed to rebuild its immediate.
module li_expander (
  input  logic          clk,
  input  logic          reset,
  li_expander_if.slave  bus,
  output logic [15:0]   emit_count
);

  localparam int unsigned CNT_W = 16;

  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [1:0] EOP_SIGN  = 2'b00;
  localparam logic [1:0] EOP_ZERO  = 2'b01;
  localparam logic [1:0] EOP_UPPER = 2'b10;

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_e;

  state_e             state_q, state_d;
  logic [31:0]        instr_q, instr_d;
  logic [1:0]         eop_q, eop_d;
  logic               last_q, last_d;
  logic [15:0]        lo_q, lo_d;
  logic [4:0]         rt_q, rt_d;
  logic               two_q, two_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               accept;
  logic               handshake;
  logic               fits_sext;

  assign bus.in_ready  = (state_q == IDLE) && !reset;
  assign bus.out_valid = (state_q != IDLE);
  assign bus.out_instr = instr_q;
  assign bus.out_eop   = eop_q;
  assign bus.out_last  = last_q;
  assign emit_count    = count_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign handshake = bus.out_valid && bus.out_ready;
  // Upper 17 bits identical means the value survives 16-bit sign extension.
  assign fits_sext = (&bus.in_value[31:15]) || !(|bus.in_value[31:15]);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = FIRST;
      FIRST:   if (bus.out_ready) state_d = two_q ? SECOND : IDLE;
      SECOND:  if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: classify at accept, load word 2 on word-1 handshake
  always_comb begin
    instr_d = instr_q;
    eop_d   = eop_q;
    last_d  = last_q;
    lo_d    = lo_q;
    rt_d    = rt_q;
    two_d   = two_q;
    count_d = count_q + CNT_W'(handshake);
    case (state_q)
      IDLE: begin
        if (accept) begin
          lo_d  = bus.in_value[15:0];
          rt_d  = bus.in_rt;
          two_d = 1'b0;
          last_d = 1'b1;
          if (fits_sext) begin
            instr_d = {OP_ADDIU, 5'd0, bus.in_rt, bus.in_value[15:0]};
            eop_d   = EOP_SIGN;
          end else if (bus.in_value[31:16] == 16'h0000) begin
            instr_d = {OP_ORI, 5'd0, bus.in_rt, bus.in_value[15:0]};
            eop_d   = EOP_ZERO;
          end else begin
            instr_d = {OP_LUI, 5'd0, bus.in_rt, bus.in_value[31:16]};
            eop_d   = EOP_UPPER;
            if (bus.in_value[15:0] != 16'h0000) begin
              two_d  = 1'b1;
              last_d = 1'b0;
            end
          end
        end
      end
      FIRST: begin
        if (bus.out_ready && two_q) begin
          instr_d = {OP_ORI, rt_q, rt_q, lo_q};
          eop_d   = EOP_ZERO;
          last_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= 32'h0;
      eop_q   <= EOP_SIGN;
      last_q  <= 1'b0;
      lo_q    <= 16'h0;
      rt_q    <= 5'd0;
      two_q   <= 1'b0;
      count_q <= '0;
    end else begin
      instr_q <= instr_d;
      eop_q   <= eop_d;
      last_q  <= last_d;
      lo_q    <= lo_d;
      rt_q    <= rt_d;
      two_q   <= two_d;
      count_q <= count_d;
    end
  end

endmodule
